vga_sync: RTL and testbench
===========================

VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 SHALL have parameters (name, default, meaning): H_DISPLAY 640 visible columns; H_FRONT 16 h front porch; H_SYNC 96 h sync width; H_BACK 48 h back porch; V_DISPLAY 480 visible lines; V_FRONT 10 v front porch; V_SYNC 2 v sync width; V_BACK 33 v back porch.
REQ-002 SHALL have port clock_50  input  1  system clock, 50 MHz; all state on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port clock_25  output  1  registered pixel-rate enable toggling every clock_50 cycle.
REQ-005 SHALL have port pix_x  output  10  current column counter.
REQ-006 SHALL have port pix_y  output  10  current line counter.
REQ-007 SHALL have port video_on  output  1  high while (pix_x, pix_y) is inside the visible area.
REQ-008 SHALL have port hsync  output  1  horizontal sync, active-low.
REQ-009 SHALL have port vsync  output  1  vertical sync, active-low.
REQ-010 SHALL use exactly one clock; reset is asynchronous and active-low.

Function
REQ-011 SHALL derive H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
REQ-012 SHALL toggle clock_25 on every clock_50 edge; a "pixel tick" is a clock_50 edge at which clock_25 is 1 before the edge.
REQ-013 SHALL hold pix_x, pix_y, video_on, hsync and vsync constant on non-tick edges.
REQ-014 SHALL on each pixel tick increment pix_x; when pix_x = H_TOTAL-1, SHALL wrap pix_x to 0 on the same tick.
REQ-015 SHALL increment pix_y only on ticks where pix_x wraps; when pix_y = V_TOTAL-1 at that wrap, SHALL wrap pix_y to 0 simultaneously.
REQ-016 SHALL register video_on, hsync, vsync from the next counter values so they are cycle-aligned with pix_x/pix_y (zero relative latency).
REQ-017 SHALL drive video_on = 1 iff pix_x < H_DISPLAY and pix_y < V_DISPLAY.
REQ-018 SHALL drive hsync = 0 iff H_DISPLAY+H_FRONT <= pix_x < H_DISPLAY+H_FRONT+H_SYNC (656..751 default).
REQ-019 SHALL drive vsync = 0 iff V_DISPLAY+V_FRONT <= pix_y < V_DISPLAY+V_FRONT+V_SYNC (490..491 default), independent of pix_x.
REQ-020 SHALL never present pix_x >= H_TOTAL or pix_y >= V_TOTAL.
REQ-021 SHALL produce one frame every H_TOTAL*V_TOTAL pixel ticks (840000 clock_50 cycles default).

Reset
REQ-022 SHALL while reset_n = 0 force: clock_25 = 0, pix_x = H_TOTAL-1 (799), pix_y = V_TOTAL-1 (524), video_on = 0, hsync = 1, vsync = 1.
REQ-023 SHALL, after reset_n rises, make the first pixel tick (second clock_50 edge) land on pix_x = 0, pix_y = 0, video_on = 1.
REQ-024 SHALL, on reset asserted mid-frame, return all outputs to REQ-022 values immediately, without waiting for a clock edge.

Configuration
REQ-025 SHALL, when macro VGA_FRAME_TICK_EN is defined, add output port frame_tick (1 bit), registered, high for exactly one clock_50 cycle following the pixel tick that loads pix_x = 0, pix_y = 0; reset value 0.
REQ-026 SHALL, when VGA_FRAME_TICK_EN is undefined, omit frame_tick entirely; all other behaviour identical.

Verification
REQ-027 Reset release: reset_n 0->1 -> clock_25 0,1,0,...; at 2nd edge pix_x=0, pix_y=0, video_on=1, hsync=1, vsync=1.
REQ-028 Line timing: run one line -> hsync low for exactly 192 clock_50 cycles starting when pix_x=656; video_on falls at pix_x=640; pix_x 799->0 increments pix_y.
REQ-029 Frame wrap: at pix_x=799, pix_y=524 next tick -> pix_x=0, pix_y=0; vsync low for exactly 2 lines (3200 clock_50 cycles) at pix_y=490..491; frame period 840000 cycles.
REQ-030 Mid-frame reset: assert reset_n=0 at pix_x=300, pix_y=200 between edges -> outputs immediately 799/524/video_on=0/hsync=1/vsync=1; release -> restarts per REQ-027.
REQ-031 Visible-area check: over a full frame video_on high for exactly 307200 ticks, never high when pix_x>=640 or pix_y>=480.
REQ-032 With VGA_FRAME_TICK_EN: over 3 frames -> frame_tick pulses 3 times, each 1 cycle wide, 840000 cycles apart; without macro the port is absent and compile succeeds.

Source files
------------

// File: rtl/vga_sync.sv
// vga_sync: VGA timing generator. From a 50 MHz clock it makes a 25 MHz
// pixel-rate enable, column and line counters, a visible-area flag and
// active-low horizontal and vertical sync pulses.
//
// Ports
//   clock_50    in   system clock; all state changes on its rising edge
//   reset_n     in   asynchronous active-low reset
//   clock_25    out  registered pixel enable, toggles every clock_50 cycle
//   pix_x       out  [9:0] current column (0 .. H_TOTAL-1)
//   pix_y       out  [9:0] current line   (0 .. V_TOTAL-1)
//   video_on    out  high while (pix_x, pix_y) is in the visible area
//   hsync       out  horizontal sync, active-low
//   vsync       out  vertical sync, active-low
//   frame_tick  out  (only with VGA_FRAME_TICK_EN) one clock_50 cycle pulse
//                    after the pixel tick that loads pix_x = 0, pix_y = 0
//
// Optional feature macro: VGA_FRAME_TICK_EN adds the frame_tick output.
//
// Reset parks the counters on the last pixel of the frame so the first
// pixel tick after release lands on (0,0) without a special case.
module vga_sync #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clock_50,
  input  logic       reset_n,
  output logic       clock_25,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync
`ifdef VGA_FRAME_TICK_EN
  ,
  output logic       frame_tick
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  // A pixel tick is an edge at which the enable is already high.
  logic       tick;
  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       vo_next;
  logic       hs_next;
  logic       vs_next;

  assign tick = clock_25;

  // Next counter values; held on non-tick edges.
  always_comb begin
    x_next = pix_x;
    y_next = pix_y;
    if (tick) begin
      if (pix_x == X_LAST) begin
        x_next = '0;
        if (pix_y == Y_LAST) y_next = '0;
        else                 y_next = pix_y + 10'd1;
      end else begin
        x_next = pix_x + 10'd1;
      end
    end
  end

  // Decode from the next counter values so the registered flags line up
  // with the registered counters on the same edge.
  always_comb begin
    vo_next = (x_next < X_VIS) && (y_next < Y_VIS);
    hs_next = !((x_next >= HS_START) && (x_next < HS_END));
    vs_next = !((y_next >= VS_START) && (y_next < VS_END));
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      clock_25 <= 1'b0;
      pix_x    <= X_LAST;
      pix_y    <= Y_LAST;
      video_on <= 1'b0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
    end else begin
      clock_25 <= ~clock_25;
      if (tick) begin
        pix_x    <= x_next;
        pix_y    <= y_next;
        video_on <= vo_next;
        hsync    <= hs_next;
        vsync    <= vs_next;
      end
    end
  end

`ifdef VGA_FRAME_TICK_EN
  // The following edge is never a tick, so the pulse is one cycle wide.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) frame_tick <= 1'b0;
    else          frame_tick <= tick && (x_next == '0) && (y_next == '0);
  end
`endif

endmodule

// File: tb/tb_vga_sync.sv
module tb_vga_sync;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // u_a: default 640x480 timing; u_b: tiny 15x8 frame for whole-frame checks
  logic       a_c25, a_vo, a_hs, a_vs;
  logic [9:0] a_x, a_y;
  logic       b_c25, b_vo, b_hs, b_vs;
  logic [9:0] b_x, b_y;
`ifdef VGA_FRAME_TICK_EN
  logic       a_ft, b_ft;
`endif

  vga_sync u_a (
    .clock_50(clk), .reset_n(rst_n), .clock_25(a_c25),
    .pix_x(a_x), .pix_y(a_y), .video_on(a_vo), .hsync(a_hs), .vsync(a_vs)
`ifdef VGA_FRAME_TICK_EN
    , .frame_tick(a_ft)
`endif
  );

  vga_sync #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_b (
    .clock_50(clk), .reset_n(rst_n), .clock_25(b_c25),
    .pix_x(b_x), .pix_y(b_y), .video_on(b_vo), .hsync(b_hs), .vsync(b_vs)
`ifdef VGA_FRAME_TICK_EN
    , .frame_tick(b_ft)
`endif
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_a_c25"}, a_c25, 0);
    chk({tag, "_a_x"},   a_x, 799);
    chk({tag, "_a_y"},   a_y, 524);
    chk({tag, "_a_vo"},  a_vo, 0);
    chk({tag, "_a_hs"},  a_hs, 1);
    chk({tag, "_a_vs"},  a_vs, 1);
    chk({tag, "_b_x"},   b_x, 14);
    chk({tag, "_b_y"},   b_y, 7);
    chk({tag, "_b_vo"},  b_vo, 0);
    chk({tag, "_b_hs"},  b_hs, 1);
    chk({tag, "_b_vs"},  b_vs, 1);
`ifdef VGA_FRAME_TICK_EN
    chk({tag, "_a_ft"},  a_ft, 0);
    chk({tag, "_b_ft"},  b_ft, 0);
`endif
  endtask

  // Release between edges; first edge only raises clock_25, second ticks.
  task automatic release_checks(input string tag);
    rst_n = 1'b1;
    @(negedge clk);
    chk({tag, "_e1_c25"}, a_c25, 1);
    chk({tag, "_e1_x"},   a_x, 799);
    chk({tag, "_e1_bx"},  b_x, 14);
    @(negedge clk);
    chk({tag, "_e2_c25"}, a_c25, 0);
    chk({tag, "_e2_x"},   a_x, 0);
    chk({tag, "_e2_y"},   a_y, 0);
    chk({tag, "_e2_vo"},  a_vo, 1);
    chk({tag, "_e2_hs"},  a_hs, 1);
    chk({tag, "_e2_vs"},  a_vs, 1);
    chk({tag, "_e2_bx"},  b_x, 0);
    chk({tag, "_e2_by"},  b_y, 0);
    chk({tag, "_e2_bvo"}, b_vo, 1);
`ifdef VGA_FRAME_TICK_EN
    chk({tag, "_e2_ft"},  b_ft, 1);
`endif
  endtask

  // line-test state
  int  cyc, vo_fall_x, hs_first_x, hs_low, vs_low_line, prev_x;
  bit  done;
  // frame-test state
  int  vo_cnt, hs_cnt, vs_cnt, bad_vis, bad_range, wraps, first_wrap, last_wrap;
  int  pb_x, pb_y;
  int  ft_cnt, ft_first, ft_last;
  bit  found;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_checks("por");
    release_checks("rel1");

    // One full line on the default-timing instance.
    cyc = 0; vo_fall_x = -1; hs_first_x = -1; hs_low = 0; vs_low_line = 0;
    prev_x = int'(a_x); done = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (a_y == 10'd1) begin
        done = 1;
        chk("line_wrap_x", a_x, 0);
        chk("line_prev_x", prev_x, 799);
        chk("line_len", cyc, 1600);
      end else begin
        if (!a_vo && vo_fall_x < 0) vo_fall_x = int'(a_x);
        if (!a_hs) begin
          if (hs_low == 0) hs_first_x = int'(a_x);
          hs_low++;
        end
        if (!a_vs) vs_low_line++;
      end
      prev_x = int'(a_x);
    end
    chk("line_done", done, 1);
    chk("vo_fall_x", vo_fall_x, 640);
    chk("hs_start_x", hs_first_x, 656);
    chk("hs_low_cyc", hs_low, 192);
    chk("vs_low_line0", vs_low_line, 0);

    // Reset again between edges, then three frames on the small instance.
    rst_n = 1'b0;
    #1;
    reset_checks("rst2");
    repeat (2) @(negedge clk);
    release_checks("rel2");

    vo_cnt = 0; hs_cnt = 0; vs_cnt = 0; bad_vis = 0; bad_range = 0;
    wraps = 0; first_wrap = -1; last_wrap = -1; pb_x = 0; pb_y = 0;
    ft_cnt = 0; ft_first = -1; ft_last = -1;
    for (int s = 0; s < 720; s++) begin
      if (s > 0) @(negedge clk);
      if (s < 240) begin
        if (b_vo)  vo_cnt++;
        if (!b_hs) hs_cnt++;
        if (!b_vs) vs_cnt++;
      end
      if (b_vo && (b_x >= 10'd8 || b_y >= 10'd4)) bad_vis++;
      if (b_x >= 10'd15 || b_y >= 10'd8) bad_range++;
      if (s > 0 && pb_x == 14 && pb_y == 7 && (b_x != 10'd14 || b_y != 10'd7)) begin
        chk("frame_wrap_x", b_x, 0);
        chk("frame_wrap_y", b_y, 0);
        if (first_wrap < 0) first_wrap = s;
        else chk("frame_period", s - last_wrap, 240);
        last_wrap = s;
        wraps++;
      end
`ifdef VGA_FRAME_TICK_EN
      if (b_ft) begin
        if (ft_last >= 0) chk("ft_period", s - ft_last, 240);
        if (ft_first < 0) ft_first = s;
        ft_last = s;
        ft_cnt++;
      end
`endif
      pb_x = int'(b_x);
      pb_y = int'(b_y);
    end
    chk("vis_cycles", vo_cnt, 64);
    chk("hs_cycles", hs_cnt, 48);
    chk("vs_cycles", vs_cnt, 60);
    chk("vis_outside", bad_vis, 0);
    chk("out_of_range", bad_range, 0);
    chk("first_wrap", first_wrap, 240);
    chk("wrap_count", wraps, 2);
`ifdef VGA_FRAME_TICK_EN
    chk("ft_first", ft_first, 0);
    chk("ft_count", ft_cnt, 3);
`endif

    // Mid-frame reset on the small instance at (5,2).
    found = 0;
    for (int s = 0; s < 300 && !found; s++) begin
      @(negedge clk);
      if (b_x == 10'd5 && b_y == 10'd2) found = 1;
    end
    chk("mid_found", found, 1);
    chk("mid_pre_vo", b_vo, 1);
    rst_n = 1'b0;
    #1;
    reset_checks("mid");
    repeat (2) @(negedge clk);
    reset_checks("mid_hold");
    release_checks("rel3");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
